// File: rtl/rvv_backend_mul_unit_lane.sv
// Elastic SIMD integer multiplier lane group for the RVV MUL unit (vmul/vmulh/vmulhu/vmulhsu).
// Define RVV_MUL_LANE_PIPE2_EN for a second output register stage (latency 2, capacity 2).
module rvv_backend_mul_unit_lane #(
  parameter int NUM_LANE = 4,
  parameter int TAG_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [32*NUM_LANE-1:0]  in0,
  input  logic [32*NUM_LANE-1:0]  in1,
  input  logic                    in0_is_signed,
  input  logic                    in1_is_signed,
  input  logic [1:0]              sew,
  input  logic                    high,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NUM_LANE-1:0]  out_data,
  output logic [TAG_W-1:0]        out_tag
);

  localparam int DW = 32 * NUM_LANE;

  // Operands are sign/zero-extended to 2*SEW bits; the product modulo 2^(2*SEW) is then
  // exactly the low 2*SEW bits of the (2*SEW+2)-bit signed product, so unsigned math suffices.
  function automatic logic [31:0] mul_lane(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        a_s,
    input logic        b_s,
    input logic [1:0]  sw,
    input logic        hi
  );
    logic [31:0] r;
    logic [15:0] a8, b8, p8;
    logic [31:0] a16, b16, p16;
    logic [63:0] a32, b32, p32;
    r = '0;
    a8 = '0; b8 = '0; p8 = '0;
    a16 = '0; b16 = '0; p16 = '0;
    a32 = '0; b32 = '0; p32 = '0;
    case (sw)
      2'd0: begin
        for (int e = 0; e < 4; e++) begin
          a8 = {{8{a_s & a[8*e+7]}}, a[8*e +: 8]};
          b8 = {{8{b_s & b[8*e+7]}}, b[8*e +: 8]};
          p8 = a8 * b8;
          r[8*e +: 8] = hi ? p8[15:8] : p8[7:0];
        end
      end
      2'd1: begin
        for (int e = 0; e < 2; e++) begin
          a16 = {{16{a_s & a[16*e+15]}}, a[16*e +: 16]};
          b16 = {{16{b_s & b[16*e+15]}}, b[16*e +: 16]};
          p16 = a16 * b16;
          r[16*e +: 16] = hi ? p16[31:16] : p16[15:0];
        end
      end
      default: begin
        a32 = {{32{a_s & a[31]}}, a};
        b32 = {{32{b_s & b[31]}}, b};
        p32 = a32 * b32;
        r   = hi ? p32[63:32] : p32[31:0];
      end
    endcase
    return r;
  endfunction

  logic [DW-1:0]    prod_d;
  logic             out_valid_q;
  logic [DW-1:0]    out_data_q;
  logic [TAG_W-1:0] out_tag_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    prod_d = '0;
    for (int l = 0; l < NUM_LANE; l++) begin
      prod_d[32*l +: 32] = mul_lane(in0[32*l +: 32], in1[32*l +: 32],
                                    in0_is_signed, in1_is_signed, sew, high);
    end
  end

  // Output stage can take new contents when empty or being drained this cycle.
  assign in_ready  = !out_valid_q || out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;

`ifdef RVV_MUL_LANE_PIPE2_EN
  logic             s0_valid_q;
  logic [DW-1:0]    s0_data_q;
  logic [TAG_W-1:0] s0_tag_q;

  // Stage 0 always empties when in_ready is high, because stage 1 is then able to load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid_q  <= 1'b0;
      s0_data_q   <= '0;
      s0_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (in_ready) begin
      s0_valid_q  <= in_valid;
      out_valid_q <= s0_valid_q;
      if (in_valid) begin
        s0_data_q <= prod_d;
        s0_tag_q  <= in_tag;
      end
      if (s0_valid_q) begin
        out_data_q <= s0_data_q;
        out_tag_q  <= s0_tag_q;
      end
    end
  end
`else
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: data/tag registers are reset too, so out_data and out_tag read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
    end else if (in_ready) begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= prod_d;
        out_tag_q  <= in_tag;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvv_backend_mul_unit_lane.sv
// Directed self-checking bench for rvv_backend_mul_unit_lane (either pipeline build).
module tb_rvv_backend_mul_unit_lane;

  localparam int NL    = 4;
  localparam int TAG_W = 4;
  localparam int DW    = 32 * NL;
`ifdef RVV_MUL_LANE_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    in0 = '0;
  logic [DW-1:0]    in1 = '0;
  logic             in0_is_signed = 1'b0;
  logic             in1_is_signed = 1'b0;
  logic [1:0]       sew = 2'd0;
  logic             high = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [TAG_W-1:0] out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rvv_backend_mul_unit_lane #(.NUM_LANE(NL), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1),
    .in0_is_signed(in0_is_signed), .in1_is_signed(in1_is_signed),
    .sew(sew), .high(high), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_stream(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 3);
    return {(DW/8){b}};
  endfunction

  function automatic logic [DW-1:0] exp_bp(input int t);
    logic [15:0] h;
    h = 16'(t + 5);
    return {NL{h, h}};
  endfunction

  task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s0, input logic s1, input logic [1:0] sw,
                         input logic hi, input logic [31:0] exp);
    in0 = {NL{a}}; in1 = {NL{b}};
    in0_is_signed = s0; in1_is_signed = s1; sew = sw; high = hi;
    in_tag = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
    end
    check({name, "_valid"}, DW'(out_valid), DW'(1));
    check(name, out_data, {NL{exp}});
    @(posedge clk); #1;
  endtask

  task automatic drive_bp(input int t);
    in0 = {NL{32'(t + 5)}}; in1 = {NL{32'h0001_0001}};
    in0_is_signed = 1'b0; in1_is_signed = 1'b0; sew = 2'd2; high = 1'b0;
    in_tag = TAG_W'(t);
  endtask

  initial begin
    int inflight;
    int next_t;
    int q[$];

    // Reset state
    #2;
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_tag", DW'(out_tag), DW'(0));
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("rst_in_ready", DW'(in_ready), DW'(1));

    // Byte products
    run_one("b_ss_hi", 32'h8080_8080, 32'h0202_0202, 1, 1, 2'd0, 1, 32'hFFFF_FFFF);
    run_one("b_uu_hi", 32'h8080_8080, 32'h0202_0202, 0, 0, 2'd0, 1, 32'h0101_0101);
    run_one("b_ss_lo", 32'h8080_8080, 32'h0202_0202, 1, 1, 2'd0, 0, 32'h0000_0000);
    run_one("b_uu_lo", 32'h8080_8080, 32'h0202_0202, 0, 0, 2'd0, 0, 32'h0000_0000);
    run_one("b_mix_lo", 32'h100F_0302, 32'h1011_0507, 0, 0, 2'd0, 0, 32'h00FF_0F0E);
    run_one("b_mix_hi", 32'h100F_0302, 32'h1011_0507, 0, 0, 2'd0, 1, 32'h0100_0000);
    // Halfword products
    run_one("h_su_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 2'd1, 1, 32'hFFFF_FFFF);
    run_one("h_su_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 2'd1, 0, 32'h0001_0001);
    run_one("h_ss_hi", 32'h8000_0003, 32'h8000_0005, 1, 1, 2'd1, 1, 32'h4000_0000);
    run_one("h_ss_lo", 32'h8000_0003, 32'h8000_0005, 1, 1, 2'd1, 0, 32'h0000_000F);
    // Word products, all lanes
    run_one("w_ss_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 2'd2, 1, 32'h0000_0000);
    run_one("w_ss_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 2'd2, 0, 32'h0000_0001);
    run_one("w_uu_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'd2, 1, 32'hFFFF_FFFE);
    run_one("w_su_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 2'd2, 1, 32'hFFFF_FFFF);
    run_one("w_sew3_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2'd3, 1, 32'hFFFF_FFFE);

    // Back-to-back stream of 8 tagged operations
    out_ready = 1'b1;
    for (int c = 0; c < 8 + LAT - 1; c++) begin
      if (c < 8) begin
        in0 = {(DW/8){8'(c + 1)}}; in1 = {(DW/8){8'd3}};
        in0_is_signed = 1'b0; in1_is_signed = 1'b0; sew = 2'd0; high = 1'b0;
        in_tag = TAG_W'(c); in_valid = 1'b1;
        #1;
        check("stream_in_ready", DW'(in_ready), DW'(1));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c - LAT + 1 >= 0) begin
        check("stream_valid", DW'(out_valid), DW'(1));
        check("stream_tag", DW'(out_tag), DW'(c - LAT + 1));
        check("stream_data", out_data, exp_stream(c - LAT + 1));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("stream_empty", DW'(out_valid), DW'(0));

    // Backpressure: out_ready low for 3 cycles while offering operations
    inflight = 0; next_t = 1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_bp(next_t); in_valid = 1'b1;
      #1;
      check("bp_in_ready", DW'(in_ready), DW'(inflight < LAT));
      if (inflight < LAT) begin
        q.push_back(next_t); inflight++; next_t++;
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        check("bp_hold_valid", DW'(out_valid), DW'(1));
        check("bp_hold_tag", DW'(out_tag), DW'(q[0]));
        check("bp_hold_data", out_data, exp_bp(q[0]));
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      #1;
      check("drain_valid", DW'(out_valid), DW'(1));
      check("drain_tag", DW'(out_tag), DW'(q[k]));
      check("drain_data", out_data, exp_bp(q[k]));
      @(posedge clk); #1;
    end
    check("drain_empty", DW'(out_valid), DW'(0));

    // Reset with the pipeline full
    inflight = 0; out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_bp(next_t); in_valid = 1'b1;
      #1;
      if (in_ready) inflight++;
      next_t++;
      @(posedge clk); #1;
    end
    check("fill_count", DW'(inflight), DW'(LAT));
    check("fill_valid", DW'(out_valid), DW'(1));
    in_valid = 1'b0;
    #2; rst = 1'b1; #1;
    check("mid_rst_valid", DW'(out_valid), DW'(0));
    check("mid_rst_data", out_data, '0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("post_rst_idle", DW'(out_valid), DW'(0));
    end
    run_one("post_rst_op", 32'h0000_0007, 32'h0000_0006, 0, 0, 2'd2, 0, 32'h0000_002A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
